avl_sram_slave: RTL and testbench

//  Avalon-MM slave (responder) fronting a word-organised on-chip RAM; the far end of the core's Avalon master port.

---
 rtl/avl_sram_slave_if.sv | 24 ++
 rtl/avl_sram_slave.sv | 106 ++++++++++
 tb/tb_avl_sram_slave.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/avl_sram_slave_if.sv
// Avalon-MM single-beat bus between a master and the SRAM slave.
// Master drives request/address/data; slave returns readdata and waitrequest.
interface avl_sram_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] writedata;
  logic [3:0]            byteenable;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  waitrequest;

  modport master (
    output address, writedata, byteenable, read, write,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, writedata, byteenable, read, write,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avl_sram_slave.sv
// Avalon-MM SRAM responder; each transfer takes WAIT_CYCLES+2 cycles (waitrequest high for WAIT_CYCLES+1).
// Backpressure: waitrequest stalls the master, which holds its inputs until waitrequest drops.
module avl_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  avl_sram_slave_if.slave  avl
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] readdata_q, readdata_d;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  req;
  logic                  in_range;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  mem_we;
  logic                  waitreq;
  logic                  addr_lsb_unused;

  // Byte offset bits never index the RAM; lane selection is carried by byteenable.
  assign addr_lsb_unused = &{1'b0, avl.address[1:0]};

  assign req      = avl.read | avl.write;
  assign mem_idx  = avl.address[IDX_W+1:2];
  assign in_range = (avl.address[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign rd_word  = in_range ? mem[mem_idx] : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    readdata_d = readdata_q;
    waitreq    = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        waitreq = req;
        if (req) begin
          state_d = ST_BUSY;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end
      end
      ST_BUSY: begin
        waitreq = 1'b1;
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d    = ST_DONE;
          // Writes (including the illegal read+write case) return zero.
          readdata_d = avl.write ? '0 : rd_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        mem_we  = avl.write & in_range;
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) begin
      waitreq = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
    end
  end

  // RAM contents survive reset; reset only suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (avl.byteenable[i]) begin
          mem[mem_idx][8*i +: 8] <= avl.writedata[8*i +: 8];
        end
      end
    end
  end

  assign avl.readdata    = readdata_q;
  assign avl.waitrequest = waitreq;

endmodule

// File: tb/tb_avl_sram_slave.sv
// Directed bench for avl_sram_slave: two instances (WAIT_CYCLES=1 and 3) with scoreboard monitors.
module tb_avl_sram_slave;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avl_sram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if1 ();
  avl_sram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if3 ();

  avl_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .avl   (if1.slave)
  );

  avl_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .avl   (if3.slave)
  );

  typedef struct {
    int          cyc;
    bit          chk;
    logic [31:0] dat;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t m1, m3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (sel) begin
      if3.read = rd; if3.write = wr; if3.address = a; if3.writedata = wd; if3.byteenable = be;
    end else begin
      if1.read = rd; if1.write = wr; if1.address = a; if1.writedata = wd; if1.byteenable = be;
    end
  endtask

  function automatic logic wreq(input bit sel);
    return sel ? if3.waitrequest : if1.waitrequest;
  endfunction

  // One transfer: completion expected WAIT_CYCLES+1 cycles after the request appears.
  task automatic xfer(input bit sel, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input bit chk,
                      input logic [31:0] exp);
    exp_t e;
    bit   done;
    @(posedge clk); #1;
    drive(sel, rd, wr, a, wd, be);
    e.cyc = cyc + (sel ? 3 : 1) + 1;
    e.chk = chk;
    e.dat = exp;
    if (sel) q3.push_back(e); else q1.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!wreq(sel)) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout addr=%h waitrequest still high, required low within 50 cycles", a);
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, a, wd, be);
  endtask

  always @(negedge clk) begin
    if (!reset && (if1.read || if1.write) && !if1.waitrequest) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon1_unexpected completion at cycle %0d, required none", cyc);
      end else begin
        m1 = q1.pop_front();
        check("mon1_cycle", 32'(cyc), 32'(m1.cyc));
        if (m1.chk) check("mon1_rdata", if1.readdata, m1.dat);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && (if3.read || if3.write) && !if3.waitrequest) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon3_unexpected completion at cycle %0d, required none", cyc);
      end else begin
        m3 = q3.pop_front();
        check("mon3_cycle", 32'(cyc), 32'(m3.cyc));
        if (m3.chk) check("mon3_rdata", if3.readdata, m3.dat);
      end
    end
  end

  initial begin
    int   c0;
    exp_t e;
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset held with a read pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_waitreq", {31'd0, if1.waitrequest}, 32'd1);
      check("rst_rdata", if1.readdata, 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    if1.read = 1'b0;
    @(negedge clk);
    check("idle_waitreq", {31'd0, if1.waitrequest}, 32'd0);

    // Word write/read, and byte offset ignored for indexing.
    xfer(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    xfer(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF);
    xfer(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 4'h1, 1'b1, 32'hDEADBEEF);

    // Byte lanes, then an all-disabled write.
    xfer(1'b0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0);
    xfer(1'b0, 1'b0, 1'b1, 32'h20, 32'h0000AA00, 4'b0010, 1'b0, 32'h0);
    xfer(1'b0, 1'b0, 1'b1, 32'h20, 32'hBBBB0000, 4'b1100, 1'b0, 32'h0);
    xfer(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b1, 32'hBBBBAA44);
    xfer(1'b0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0);
    xfer(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b1, 32'hBBBBAA44);

    // Out of range and read+write together.
    xfer(1'b0, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, 32'h0);
    xfer(1'b0, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
    xfer(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b1, 32'h0);
    xfer(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 32'h0BADF00D);
    xfer(1'b0, 1'b1, 1'b1, 32'h30, 32'h5A5A5A5A, 4'hF, 1'b1, 32'h0);
    xfer(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 1'b1, 32'h5A5A5A5A);

    // Abort by reset during BUSY.
    xfer(1'b0, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0);
    xfer(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, 32'h12345678);

    // Abort by withdrawing the write during BUSY.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    if1.write = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("withdraw_waitreq", {31'd0, if1.waitrequest}, 32'd0);
    xfer(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, 32'h12345678);

    // Back-to-back reads held continuously on the WAIT_CYCLES=3 instance.
    xfer(1'b1, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      e.cyc = c0 + 4 + 5 * k;
      e.chk = 1'b1;
      e.dat = 32'hA5A5A5A5;
      q3.push_back(e);
    end
    repeat (20) @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 4'h0);

    repeat (10) @(posedge clk);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
